// File: rtl/dmux4way16_stream_if.sv
// Handshake bundle for the registered 1-to-4 word distributor: one producer
// stream in, four independently handshaked lanes out.
interface dmux4way16_stream_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] out_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_cnt
  );
endinterface

// File: rtl/dmux4way16_stream.sv
// Registered 1-to-4 word distributor: steers each accepted word into one of four
// one-word lane buffers; an empty lane reads all-zero, giving demux semantics.
module dmux4way16_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  dmux4way16_stream_if.slave bus
);

  logic [WIDTH-1:0] hold_p1 [4];
  logic [3:0]       vld_p1;
  logic [CNT_W-1:0] cnt_p1 [4];
  logic             ready;
  logic             accept;
  logic [3:0]       pop;

  // Ready looks only at the addressed lane, so a stalled lane never blocks others
  // and there is no in_valid -> in_ready path.
  assign ready  = ~vld_p1[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept = bus.in_valid & ready;
  assign pop    = vld_p1 & bus.out_ready;

  // Stage p1: lane holding registers and delivered-word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= '0;
      for (int k = 0; k < 4; k++) begin
        hold_p1[k] <= '0;
        cnt_p1[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // Accept wins over pop: a popped lane is refilled in the same cycle.
        if (accept && (bus.in_sel == 2'(k))) begin
          hold_p1[k] <= bus.in_data;
          vld_p1[k]  <= 1'b1;
        end else if (pop[k]) begin
          hold_p1[k] <= '0;
          vld_p1[k]  <= 1'b0;
        end
        if (pop[k]) begin
          cnt_p1[k] <= cnt_p1[k] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_p1;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign bus.out_data[g*WIDTH +: WIDTH] = hold_p1[g];
    assign bus.out_cnt[g*CNT_W +: CNT_W]  = cnt_p1[g];
  end

endmodule

// File: tb/tb_dmux4way16_stream.sv
// Directed-vector bench for dmux4way16_stream: reset, steering, backpressure,
// pass-through refill, streaming and counter wrap.
module tb_dmux4way16_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  dmux4way16_stream_if #(.WIDTH(16), .CNT_W(8)) bus ();

  dmux4way16_stream #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [15:0] lane(input int k);
    return bus.out_data[k*16 +: 16];
  endfunction

  function automatic logic [7:0] cnt(input int k);
    return bus.out_cnt[k*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] s);
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_data   = 16'h0;
    bus.in_sel    = 2'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    rst_n = 1'b0;
    #12;
    vecs++; if (bus.out_valid !== 4'b0000) begin errs++; $display("FAIL reset_valid got %b want 0000", bus.out_valid); end
    vecs++; if (bus.out_data !== 64'h0) begin errs++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    vecs++; if (bus.out_cnt !== 32'h0) begin errs++; $display("FAIL reset_cnt got %h want 0", bus.out_cnt); end
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    rst_n = 1'b1;
    step(); step(); step();
    vecs++; if (bus.out_valid !== 4'b0000 || bus.out_data !== 64'h0 || bus.out_cnt !== 32'h0) begin
      errs++; $display("FAIL idle_outputs got v=%b d=%h c=%h want all 0", bus.out_valid, bus.out_data, bus.out_cnt);
    end
  endtask

  task automatic test_single_steer();
    bus.in_data  = 16'h1234;
    bus.in_sel   = 2'd2;
    bus.in_valid = 1'b1;
    #1;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL steer_ready got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 4'b0100) begin errs++; $display("FAIL steer_valid got %b want 0100", bus.out_valid); end
    vecs++; if (bus.out_data !== 64'h0000_1234_0000_0000) begin errs++; $display("FAIL steer_data got %h want 0000123400000000", bus.out_data); end
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    vecs++; if (bus.out_valid !== 4'b0000 || bus.out_data !== 64'h0) begin
      errs++; $display("FAIL steer_pop got v=%b d=%h want 0000/0", bus.out_valid, bus.out_data);
    end
    vecs++; if (cnt(2) !== 8'd1) begin errs++; $display("FAIL steer_cnt_c got %0d want 1", cnt(2)); end
  endtask

  task automatic test_backpressure();
    send(16'hAAAA, 2'd1);
    bus.in_data  = 16'h5555;
    bus.in_sel   = 2'd1;
    bus.in_valid = 1'b1;
    #1;
    vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_stalled got %b want 0", bus.in_ready); end
    step();
    vecs++; if (lane(1) !== 16'hAAAA || bus.out_valid !== 4'b0010) begin
      errs++; $display("FAIL bp_hold got b=%h v=%b want AAAA/0010", lane(1), bus.out_valid);
    end
    bus.in_data = 16'h7777;
    bus.in_sel  = 2'd3;
    #1;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_other got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    vecs++; if (lane(3) !== 16'h7777 || lane(1) !== 16'hAAAA || bus.out_valid !== 4'b1010) begin
      errs++; $display("FAIL bp_other_lane got d=%h b=%h v=%b want 7777/AAAA/1010", lane(3), lane(1), bus.out_valid);
    end
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;
    vecs++; if (bus.out_cnt !== {8'd1, 8'd1, 8'd1, 8'd0}) begin
      errs++; $display("FAIL bp_counts got %h want 01010100", bus.out_cnt);
    end
  endtask

  task automatic test_passthrough();
    send(16'h1111, 2'd0);
    bus.out_ready = 4'b0001;
    bus.in_data   = 16'hBEEF;
    bus.in_sel    = 2'd0;
    bus.in_valid  = 1'b1;
    #1;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL pt_ready got %b want 1", bus.in_ready); end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    vecs++; if (lane(0) !== 16'hBEEF || bus.out_valid[0] !== 1'b1) begin
      errs++; $display("FAIL pt_refill got a=%h v=%b want BEEF/1", lane(0), bus.out_valid[0]);
    end
    vecs++; if (cnt(0) !== 8'd1) begin errs++; $display("FAIL pt_cnt_a got %0d want 1", cnt(0)); end
  endtask

  task automatic test_streaming();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      bus.in_data  = 16'(i + 1);
      bus.in_sel   = 2'(i % 4);
      bus.in_valid = 1'b1;
      #1;
      vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready_%0d got %b want 1", i, bus.in_ready); end
      step();
      vecs++; if (lane(i % 4) !== 16'(i + 1) || bus.out_valid !== 4'(1 << (i % 4))) begin
        errs++; $display("FAIL stream_word_%0d got lane=%h v=%b want %h/%b", i, lane(i % 4), bus.out_valid, 16'(i + 1), 4'(1 << (i % 4)));
      end
    end
    bus.in_valid = 1'b0;
    step();
    vecs++; if (bus.out_valid !== 4'b0000) begin errs++; $display("FAIL stream_drain got %b want 0000", bus.out_valid); end
    vecs++; if (bus.out_cnt !== {8'd2, 8'd2, 8'd2, 8'd2}) begin
      errs++; $display("FAIL stream_counts got %h want 02020202", bus.out_cnt);
    end
    bus.out_ready = 4'b0000;
  endtask

  task automatic test_cnt_wrap();
    // Lane d starts at 2; 254 more pops land exactly on the wrap to 0.
    bus.out_ready = 4'b1000;
    bus.in_sel    = 2'd3;
    bus.in_valid  = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      bus.in_data = 16'(j);
      step();
      if (j == 255) begin
        vecs++; if (cnt(3) !== 8'd0) begin errs++; $display("FAIL wrap_zero got %0d want 0", cnt(3)); end
      end
    end
    bus.in_valid = 1'b0;
    vecs++; if (lane(3) !== 16'd256 || bus.out_valid !== 4'b1000) begin
      errs++; $display("FAIL wrap_last_word got %h v=%b want 0100/1000", lane(3), bus.out_valid);
    end
    step();
    bus.out_ready = 4'b0000;
    vecs++; if (cnt(3) !== 8'd2) begin errs++; $display("FAIL wrap_cnt_d got %0d want 2", cnt(3)); end
    vecs++; if (cnt(0) !== 8'd2 || cnt(1) !== 8'd2 || cnt(2) !== 8'd2) begin
      errs++; $display("FAIL wrap_other_cnts got %h want 020202 in low lanes", bus.out_cnt[23:0]);
    end
  endtask

  task automatic test_reset_midrun();
    send(16'hA0A0, 2'd0);
    send(16'hB1B1, 2'd1);
    vecs++; if (bus.out_valid !== 4'b0011) begin errs++; $display("FAIL mid_fill got %b want 0011", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    bus.in_data  = 16'hCCCC;
    bus.in_sel   = 2'd2;
    bus.in_valid = 1'b1;
    #1;
    vecs++; if (bus.out_valid !== 4'b0000 || bus.out_data !== 64'h0 || bus.out_cnt !== 32'h0) begin
      errs++; $display("FAIL mid_async got v=%b d=%h c=%h want all 0", bus.out_valid, bus.out_data, bus.out_cnt);
    end
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL mid_ready got %b want 1", bus.in_ready); end
    step();
    vecs++; if (bus.out_valid !== 4'b0000 || bus.out_data !== 64'h0) begin
      errs++; $display("FAIL mid_discard got v=%b d=%h want 0", bus.out_valid, bus.out_data);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step(); step();
    vecs++; if (bus.out_valid !== 4'b0000 || bus.out_data !== 64'h0 || bus.out_cnt !== 32'h0) begin
      errs++; $display("FAIL mid_release got v=%b d=%h c=%h want all 0", bus.out_valid, bus.out_data, bus.out_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_steer();
    test_backpressure();
    test_passthrough();
    test_streaming();
    test_cnt_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
